// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and the
// baud divider used by both the receive and transmit engines.
package uart_pkg;

   localparam int DEFAULT_BAUD = 115200;
   localparam int DEFAULT_OVS  = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   // Clocks per oversample tick; integer truncation.
   function automatic int baud_div(input int clk_freq, input int baud, input int ovs);
      return clk_freq / (baud * ovs);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
// Shared by the receiver (OVS=16) and the transmitter (OVS=1).
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = DEFAULT_BAUD,
   parameter int OVS      = DEFAULT_OVS
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int DIV = baud_div(CLK_FREQ, BAUD, OVS);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV < 1) begin : g_div_check
      $error("uart_baud_tick: CLK_FREQ is too low for BAUD*OVS");
   end

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst)      cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive engine, 16x oversampled mid-bit sampling, valid/ready output.
// Define UART_RECEIVER_PARITY_EN to add a parity bit, PARITY_ODD and parity_err.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = DEFAULT_BAUD,
   parameter int OVS       = DEFAULT_OVS,
   parameter int DATA_BITS = 8
`ifdef UART_RECEIVER_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
`ifdef UART_RECEIVER_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam int OSW = $clog2(OVS);
   localparam int BW  = $clog2(DATA_BITS);
   localparam logic [OSW-1:0] OS_MID   = OSW'(OVS / 2 - 1);
   localparam logic [OSW-1:0] OS_LAST  = OSW'(OVS - 1);
   localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);
`ifdef UART_RECEIVER_PARITY_EN
   localparam uart_state_t AFTER_DATA = PARITY;
`else
   localparam uart_state_t AFTER_DATA = STOP;
`endif

   if (OVS < 4 || (OVS % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8) begin : g_param_check
      $error("uart_receiver: OVS must be even and >= 4, DATA_BITS in 5..8");
   end

   logic                 tick;
   logic [1:0]           sync_q;
   logic                 rx_s;
   uart_state_t          state, state_n;
   logic [OSW-1:0]       os_cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 armed;
   logic os_clr, os_inc, bit_clr, bit_inc, shift_en, arm_set, arm_clr;
   logic frame_ok, frame_bad, stop_dec, par_sample;

   uart_baud_tick #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVS(OVS)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // NOTE: rx is asynchronous; only the second synchroniser flop may feed logic.
   assign rx_s = sync_q[1];
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_n    = state;
      os_clr     = 1'b0;
      os_inc     = 1'b0;
      bit_clr    = 1'b0;
      bit_inc    = 1'b0;
      shift_en   = 1'b0;
      arm_set    = 1'b0;
      arm_clr    = 1'b0;
      frame_ok   = 1'b0;
      frame_bad  = 1'b0;
      stop_dec   = 1'b0;
      par_sample = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (rx_s) arm_set = 1'b1;
               else if (armed) begin
                  state_n = START;
                  os_clr  = 1'b1;
               end
            end
            START: begin
               if (os_cnt == OS_MID) begin
                  state_n = rx_s ? IDLE : DATA;
                  os_clr  = 1'b1;
                  bit_clr = 1'b1;
               end else os_inc = 1'b1;
            end
            DATA: begin
               if (os_cnt == OS_LAST) begin
                  shift_en = 1'b1;
                  os_clr   = 1'b1;
                  if (bit_idx == BIT_LAST) state_n = AFTER_DATA;
                  else                     bit_inc = 1'b1;
               end else os_inc = 1'b1;
            end
`ifdef UART_RECEIVER_PARITY_EN
            PARITY: begin
               if (os_cnt == OS_LAST) begin
                  par_sample = 1'b1;
                  os_clr     = 1'b1;
                  state_n    = STOP;
               end else os_inc = 1'b1;
            end
`endif
            STOP: begin
               if (os_cnt == OS_LAST) begin
                  stop_dec  = 1'b1;
                  os_clr    = 1'b1;
                  state_n   = IDLE;
                  frame_ok  = rx_s;
                  frame_bad = !rx_s;
                  arm_clr   = !rx_s;  // a held break must go high before re-arming
               end else os_inc = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q    <= 2'b11;
         os_cnt    <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         armed     <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rx};
         frame_err <= frame_bad;
         overrun   <= 1'b0;
         if (os_clr)       os_cnt <= '0;
         else if (os_inc)  os_cnt <= os_cnt + 1'b1;
         if (bit_clr)      bit_idx <= '0;
         else if (bit_inc) bit_idx <= bit_idx + 1'b1;
         if (shift_en)     shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         if (arm_clr)      armed <= 1'b0;
         else if (arm_set) armed <= 1'b1;
         if (frame_ok && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else begin
            if (frame_ok) overrun  <= 1'b1;
            if (rx_ready) rx_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RECEIVER_PARITY_EN
   logic par_bad;

   always_ff @(posedge clk) begin
      if (!rst) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (par_sample) par_bad <= (^shreg) ^ rx_s ^ PARITY_ODD;
         parity_err <= stop_dec && par_bad;
      end
   end
`else
   logic unused_par;
   assign unused_par = par_sample;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: the stimulus side predicts bytes and flag
// pulses from the frame rules, a negedge monitor compares what the DUT presents.
module tb_uart_receiver;

   localparam int CLK_FREQ  = 6400000;
   localparam int BAUD      = 100000;
   localparam int OVS       = 16;
   localparam int DATA_BITS = 8;
   localparam int BIT_CLK   = CLK_FREQ / BAUD;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, busy;
`ifdef UART_RECEIVER_PARITY_EN
   logic       parity_err;
   bit         par_flip = 1'b0;
   int         exp_perr = 0, seen_perr = 0;
`endif

   int         n_checks = 0, n_errors = 0;
   int         exp_ferr = 0, seen_ferr = 0, exp_ovr = 0, seen_ovr = 0;
   int         valid_cycles = 0;
   logic [7:0] byte_q[$];
   bit         mon_en = 1'b0;

   always #5 clk = ~clk;

   uart_receiver #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .OVS      (OVS),
      .DATA_BITS(DATA_BITS)
`ifdef UART_RECEIVER_PARITY_EN
      , .PARITY_ODD(1'b0)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
`ifdef UART_RECEIVER_PARITY_EN
      .parity_err(parity_err),
`endif
      .busy      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: builds the wire-level frame and predicts the outcome.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok);
      bit bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_RECEIVER_PARITY_EN
      bits.push_back((^d) ^ par_flip);
      if (par_flip) exp_perr++;
`endif
      bits.push_back(stop_ok);
      if (!stop_ok)                               exp_ferr++;
      else if (byte_q.size() != 0 && !rx_ready)   exp_ovr++;
      else                                        byte_q.push_back(d);
      foreach (bits[i]) begin
         rx = bits[i];
         wait_clk(BIT_CLK);
      end
   endtask

   task automatic check_events(input string tag);
      check({tag, "_frame_err_pulses"}, seen_ferr, exp_ferr);
      check({tag, "_overrun_pulses"}, seen_ovr, exp_ovr);
`ifdef UART_RECEIVER_PARITY_EN
      check({tag, "_parity_err_pulses"}, seen_perr, exp_perr);
`endif
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2000 && byte_q.size() != 0; i++) wait_clk(1);
      check({tag, "_queue_drained"}, byte_q.size(), 0);
   endtask

   logic       prev_valid = 1'b0, prev_ready = 1'b0;
   logic [7:0] prev_data = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (frame_err) seen_ferr++;
         if (overrun)   seen_ovr++;
`ifdef UART_RECEIVER_PARITY_EN
         if (parity_err) seen_perr++;
`endif
         if (rx_valid) valid_cycles++;
         if (prev_valid && !prev_ready) begin
            check("hold_valid", rx_valid, 1);
            check("hold_data", rx_data, prev_data);
         end
         if (prev_valid && prev_ready) check("valid_clears_after_accept", rx_valid, 0);
         if (rx_valid && rx_ready) begin
            if (byte_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no byte at %0t", rx_data, $time);
            end else begin
               check("rx_data", rx_data, byte_q.pop_front());
            end
         end
         prev_valid = rx_valid;
         prev_ready = rx_ready;
         prev_data  = rx_data;
      end
   end

   initial begin
      logic [7:0] d55;
      wait_clk(3);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_overrun", overrun, 0);
      check("reset_busy", busy, 0);
      rst    = 1'b1;
      mon_en = 1'b1;
      wait_clk(2 * BIT_CLK);

      // Clean frame, consumer always ready.
      valid_cycles = 0;
      send_frame(8'hA5, 1'b1);
      wait_clk(BIT_CLK);
      check("t1_valid_cycles", valid_cycles, 1);
      check_events("t1");

      // Short low glitch on an idle line.
      valid_cycles = 0;
      rx = 1'b0;
      wait_clk(20);
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);
      check("t2_busy", busy, 0);
      check("t2_valid_cycles", valid_cycles, 0);
      check_events("t2");

      // Stop bit low followed by a held break.
      send_frame(8'h3C, 1'b0);
      for (int i = 0; i < 5; i++) begin
         wait_clk(BIT_CLK);
         check("t3_break_not_busy", busy, 0);
      end
      check("t3_valid_cycles", valid_cycles, 0);
      check_events("t3");
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);

      // Holding register full: second byte dropped.
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      wait_clk(BIT_CLK);
      check("t4_rx_data_held", rx_data, 8'h11);
      check("t4_rx_valid_held", rx_valid, 1);
      check_events("t4");
      rx_ready = 1'b1;
      drain("t4");

      // Reset in the middle of data bit 4; the aborted frame leaves no trace.
      d55 = 8'h55;
      rx  = 1'b0;
      wait_clk(BIT_CLK);
      for (int i = 0; i < 4; i++) begin
         rx = d55[i];
         wait_clk(BIT_CLK);
      end
      rx = d55[4];
      wait_clk(BIT_CLK / 2);
      rst = 1'b0;
      wait_clk(1);
      rst = 1'b1;
      check("t5_busy_after_reset", busy, 0);
      check("t5_valid_after_reset", rx_valid, 0);
      rx = 1'b1;
      wait_clk(12 * BIT_CLK);
      valid_cycles = 0;
      send_frame(8'h0F, 1'b1);
      wait_clk(BIT_CLK);
      check("t5_valid_cycles", valid_cycles, 1);
      drain("t5");
      check_events("t5");

`ifdef UART_RECEIVER_PARITY_EN
      // Even parity: 0x07 has three ones, so a parity bit of 0 is wrong.
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      wait_clk(BIT_CLK);
      par_flip = 1'b0;
      send_frame(8'h07, 1'b1);
      wait_clk(BIT_CLK);
      drain("t6");
      check_events("t6");
`endif

      // Randomised frames with occasional bad stop bits and random idle gaps.
      for (int n = 0; n < 12; n++) begin
         logic [7:0] d;
         bit         ok;
         d  = 8'($urandom);
         ok = ($urandom_range(0, 5) != 0);
`ifdef UART_RECEIVER_PARITY_EN
         par_flip = 1'($urandom_range(0, 1));
`endif
         send_frame(d, ok);
         rx = 1'b1;
         wait_clk($urandom_range(16, 200));
      end
      wait_clk(BIT_CLK);
      drain("rand");
      check_events("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
